// File: rtl/acs_pmu_64.sv
// 64-state add-compare-select / path-metric unit, K=7 rate-1/2 Viterbi.
// One ACS step per accepted symbol, with MSB normalisation and argmin.
module acs_pmu_64 #(
   parameter int PM_W      = 8,
   parameter int INIT_BIAS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            frame_start,
   input  logic [127:0]    bm0_in,
   input  logic [127:0]    bm1_in,
   output logic            out_valid,
   output logic [63:0]     dec_out,
   output logic [5:0]      best_state,
   output logic [PM_W-1:0] best_metric
);

   localparam logic [PM_W-1:0] LP_BIAS = PM_W'(INIT_BIAS);

   logic [PM_W-1:0] r_pm [64];
   logic            r_ov;
   logic [63:0]     r_dec;
   logic [5:0]      r_bst;
   logic [PM_W-1:0] r_bmin;

   logic [PM_W-1:0] w_src [64];
   logic [PM_W-1:0] w_c0  [64];
   logic [PM_W-1:0] w_c1  [64];
   logic [PM_W-1:0] w_new [64];
   logic [PM_W-1:0] w_nrm [64];
   logic [63:0]     w_dec;
   logic            w_all_msb;
   logic [5:0]      w_bst;
   logic [PM_W-1:0] w_bmin;

   // A frame start replaces the stored metrics with the init vector.
   always_comb begin : src_sel
      for (int i = 0; i < 64; i++) begin
         if (frame_start)
            w_src[i] = (i == 0) ? '0 : LP_BIAS;
         else
            w_src[i] = r_pm[i];
      end
   end

   // Predecessors of s' are {s'[4:0],0} and {s'[4:0],1}.
   always_comb begin : acs
      w_all_msb = 1'b1;
      for (int s = 0; s < 64; s++) begin
         w_c0[s]  = w_src[6'((s % 32) * 2)]
                  + PM_W'(bm0_in[2*s +: 2]);
         w_c1[s]  = w_src[6'((s % 32) * 2 + 1)]
                  + PM_W'(bm1_in[2*s +: 2]);
         w_dec[s] = (w_c1[s] < w_c0[s]);
         w_new[s] = w_dec[s] ? w_c1[s] : w_c0[s];
         w_all_msb = w_all_msb & w_new[s][PM_W-1];
      end
   end

   always_comb begin : nrm
      for (int s = 0; s < 64; s++) begin
         w_nrm[s] = w_new[s];
         if (w_all_msb)
            w_nrm[s][PM_W-1] = 1'b0;
      end
   end

   // Strict compare keeps the lowest index on ties.
   always_comb begin : argmin
      w_bmin = w_nrm[0];
      w_bst  = '0;
      for (int s = 1; s < 64; s++) begin
         if (w_nrm[s] < w_bmin) begin
            w_bmin = w_nrm[s];
            w_bst  = 6'(s);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++)
            r_pm[i] <= (i == 0) ? '0 : LP_BIAS;
         r_ov   <= 1'b0;
         r_dec  <= '0;
         r_bst  <= '0;
         r_bmin <= '0;
      end else begin
         r_ov <= in_valid;
         if (in_valid) begin
            r_pm   <= w_nrm;
            r_dec  <= w_dec;
            r_bst  <= w_bst;
            r_bmin <= w_bmin;
         end else if (frame_start) begin
            for (int i = 0; i < 64; i++)
               r_pm[i] <= (i == 0) ? '0 : LP_BIAS;
         end
      end
   end

   assign out_valid   = r_ov;
   assign dec_out     = r_dec;
   assign best_state  = r_bst;
   assign best_metric = r_bmin;

endmodule

// File: tb/tb_acs_pmu_64.sv
// Directed-vector bench for acs_pmu_64 (PM_W=8, INIT_BIAS=32).
// Table vectors plus normalisation, gap and mid-frame reset sequences.
module tb_acs_pmu_64;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         frame_start;
   logic [127:0] bm0_in;
   logic [127:0] bm1_in;
   logic         out_valid;
   logic [63:0]  dec_out;
   logic [5:0]   best_state;
   logic [7:0]   best_metric;

   int n_vec;
   int n_err;

   typedef struct {
      string        nm;
      logic         r;
      logic         f;
      logic         v;
      logic [127:0] b0;
      logic [127:0] b1;
      logic         ov;
      logic [63:0]  dec;
      logic [5:0]   bs;
      logic [7:0]   bm;
   } vec_t;

   vec_t tbl[$];

   localparam logic [127:0] ALL1 = {64{2'b01}};
   localparam logic [127:0] ALL2 = {64{2'b10}};

   acs_pmu_64 #(.PM_W(8), .INIT_BIAS(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .bm0_in      (bm0_in),
      .bm1_in      (bm1_in),
      .out_valid   (out_valid),
      .dec_out     (dec_out),
      .best_state  (best_state),
      .best_metric (best_metric)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      string nm, logic r, logic f, logic v,
      logic [127:0] b0, logic [127:0] b1,
      logic ov, logic [63:0] dec,
      logic [5:0] bs, logic [7:0] bm);
      vec_t t;
      t.nm = nm; t.r = r; t.f = f; t.v = v;
      t.b0 = b0; t.b1 = b1;
      t.ov = ov; t.dec = dec; t.bs = bs; t.bm = bm;
      return t;
   endfunction

   task automatic step(
      input string nm, input logic r, input logic f,
      input logic v, input logic [127:0] b0,
      input logic [127:0] b1, input logic eov,
      input logic [63:0] edec, input logic [5:0] ebs,
      input logic [7:0] ebm);
      rst = r; frame_start = f; in_valid = v;
      bm0_in = b0; bm1_in = b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== eov || dec_out !== edec ||
          best_state !== ebs || best_metric !== ebm) begin
         n_err++;
         $display("FAIL %s: got ov=%0b dec=%h bs=%0d bm=%0d want ov=%0b dec=%h bs=%0d bm=%0d",
                  nm, out_valid, dec_out, best_state, best_metric,
                  eov, edec, ebs, ebm);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0;
      bm0_in = '0; bm1_in = '0;

      tbl.push_back(mk("rst0", 1,0,0, '0, '0, 0, '0, 0, 0));
      tbl.push_back(mk("rst1", 1,0,0, '0, '0, 0, '0, 0, 0));
      tbl.push_back(mk("idle0",0,0,0, '0, '0, 0, '0, 0, 0));
      tbl.push_back(mk("idle1",0,0,0, '0, '0, 0, '0, 0, 0));
      tbl.push_back(mk("fs_zero",0,1,1, '0, '0, 1, '0, 0, 0));
      tbl.push_back(mk("hold0",0,0,0, '0, '0, 0, '0, 0, 0));
      tbl.push_back(mk("p0_pref",0,1,1, 128'h2, '0,
                       1, '0, 6'd32, 0));
      tbl.push_back(mk("hold1",0,0,0, '0, '0, 0, '0, 6'd32, 0));
      tbl.push_back(mk("p1_flip",0,1,1, 128'h4800, 128'h4000,
                       1, 64'h20, 0, 0));
      tbl.push_back(mk("step_all1",0,0,1, ALL1, ALL1,
                       1, '0, 0, 8'd1));
      tbl.push_back(mk("rst_mid",1,0,1, ALL2, ALL2,
                       0, '0, 0, 0));
      tbl.push_back(mk("post_rst",0,0,1, 128'h2, '0,
                       1, '0, 6'd32, 0));
      tbl.push_back(mk("fs_only",0,1,0, '0, '0,
                       0, '0, 6'd32, 0));
      tbl.push_back(mk("after_fs",0,0,1, 128'h4800, 128'h4000,
                       1, 64'h20, 0, 0));

      foreach (tbl[k])
         step(tbl[k].nm, tbl[k].r, tbl[k].f, tbl[k].v,
              tbl[k].b0, tbl[k].b1, tbl[k].ov, tbl[k].dec,
              tbl[k].bs, tbl[k].bm);

      // Normalisation run, with a gap after step 10.
      step("norm1", 0,1,1, ALL2, ALL2, 1, '0, 0, 8'd2);
      for (int n = 2; n <= 65; n++) begin
         int e;
         e = (n == 64) ? 0 : (n == 65) ? 2 : 2 * n;
         step($sformatf("norm%0d", n), 0,0,1, ALL2, ALL2,
              1, '0, 0, 8'(e));
         if (n == 10) begin
            for (int g = 0; g < 3; g++)
               step($sformatf("gap%0d", g), 0,0,0, ALL1, ALL1,
                    0, '0, 0, 8'd20);
         end
      end

      // Reset in the middle of a frame discards the step.
      step("mf1", 0,1,1, ALL2, ALL2, 1, '0, 0, 8'd2);
      for (int n = 2; n <= 10; n++)
         step($sformatf("mf%0d", n), 0,0,1, ALL2, ALL2,
              1, '0, 0, 8'(2 * n));
      step("mf_rst", 1,0,1, ALL2, ALL2, 0, '0, 0, 0);
      step("mf_fresh", 0,0,1, ALL2, ALL2, 1, '0, 0, 8'd2);
      step("mf_idle", 0,0,0, '0, '0, 0, '0, 0, 8'd2);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
